// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: 16x-oversampled 8N1 UART receiver with an RX FIFO behind a periph-bus register slave.
// Parity checking (CTRL[4:3], STATUS[5], PARITY state) is compiled in when UART_RX_PARITY_EN is defined.
module uart_rx_ctrl #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RST    = 16'd27
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic [31:0] rdata,
  input  logic        uart_rx,
  output logic        irq_rx
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [7:0] OffRxData = 8'h04;
  localparam logic [7:0] OffStatus = 8'h08;
  localparam logic [7:0] OffCtrl   = 8'h0C;
  localparam logic [7:0] OffBaud   = 8'h10;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop
`ifdef UART_RX_PARITY_EN
    , StParity
`endif
  } state_e;

  logic            sync1_q, sync2_q, rx_s;
  state_e          state_q, state_d;
  logic [3:0]      sc_q, sc_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [15:0]     div_cnt_q, div_cnt_d;
  logic [15:0]     baud_div_q, baud_div_d;
  logic            rx_en_q, rx_en_d;
  logic            irq_en_q, irq_en_d;
  logic            overrun_q, overrun_d;
  logic            frame_err_q, frame_err_d;
  logic            parity_err;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, mem_waddr;
  logic [CntW-1:0] count_q, count_d;

`ifdef UART_RX_PARITY_EN
  logic par_en_q, par_en_d, par_odd_q, par_odd_d;
  logic par_bad_q, par_bad_d, parity_err_q, parity_err_d, parity_set;
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  logic       rd_en, wr_en, ctrl_wr, baud_wr, status_wr, flush;
  logic       tick, push_req, frame_set, overrun_set;
  logic       empty, full, pop, do_push, mem_we, busy;
  logic [7:0] offset;
  logic       unused_bits;

  assign unused_bits = ^{req_wstrb, req_addr[31:8], req_wdata[31:16]};

  assign rx_s      = sync2_q;
  assign offset    = req_addr[7:0];
  assign rd_en     = req_valid & ~req_write;
  assign wr_en     = req_valid & req_write;
  assign ctrl_wr   = wr_en && (offset == OffCtrl);
  assign baud_wr   = wr_en && (offset == OffBaud);
  assign status_wr = wr_en && (offset == OffStatus);
  assign flush     = ctrl_wr & req_wdata[2];

  assign empty = (count_q == '0);
  assign full  = (count_q == CntW'(FIFO_DEPTH));
  assign busy  = (state_q != StIdle);
  assign pop   = rd_en && (offset == OffRxData) && !empty;

  // Control registers and the 16x tick divider
  always_comb begin
    rx_en_d    = ctrl_wr ? req_wdata[0] : rx_en_q;
    irq_en_d   = ctrl_wr ? req_wdata[1] : irq_en_q;
    baud_div_d = baud_div_q;
    if (baud_wr) baud_div_d = (req_wdata[15:0] == 16'd0) ? 16'd1 : req_wdata[15:0];
`ifdef UART_RX_PARITY_EN
    par_en_d  = ctrl_wr ? req_wdata[3] : par_en_q;
    par_odd_d = ctrl_wr ? req_wdata[4] : par_odd_q;
`endif
    tick = rx_en_q && (div_cnt_q == baud_div_q - 16'd1);
    if (!rx_en_q || baud_wr || tick) div_cnt_d = 16'd0;
    else                             div_cnt_d = div_cnt_q + 16'd1;
  end

  // Receive FSM; sc counts ticks within a bit, sampling at mid-bit
  always_comb begin
    state_d   = state_q;
    sc_d      = sc_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    push_req  = 1'b0;
    frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d  = par_bad_q;
    parity_set = 1'b0;
`endif
    if (!rx_en_q) begin
      state_d = StIdle;
      sc_d    = 4'd0;
    end else if (tick) begin
      unique case (state_q)
        StIdle: begin
          if (!rx_s) begin
            state_d = StStart;
            sc_d    = 4'd0;
`ifdef UART_RX_PARITY_EN
            par_bad_d = 1'b0;
`endif
          end
        end
        StStart: begin
          if (sc_q == 4'd7) begin
            sc_d = 4'd0;
            if (rx_s) begin
              state_d = StIdle;
            end else begin
              state_d = StData;
              bit_d   = 3'd0;
            end
          end else begin
            sc_d = sc_q + 4'd1;
          end
        end
        StData: begin
          sc_d = sc_q + 4'd1;
          if (sc_q == 4'd15) begin
            shift_d = {rx_s, shift_q[7:1]};
            if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = par_en_q ? StParity : StStop;
`else
              state_d = StStop;
`endif
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        StParity: begin
          sc_d = sc_q + 4'd1;
          if (sc_q == 4'd15) begin
            par_bad_d  = (rx_s != (^shift_q ^ par_odd_q));
            parity_set = par_bad_d;
            state_d    = StStop;
          end
        end
`endif
        StStop: begin
          sc_d = sc_q + 4'd1;
          if (sc_q == 4'd15) begin
            state_d = StIdle;
            if (!rx_s) frame_set = 1'b1;
`ifdef UART_RX_PARITY_EN
            else if (!par_bad_q) push_req = 1'b1;
`else
            else push_req = 1'b1;
`endif
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // FIFO pointers; a flush coincident with a push leaves just the new byte
  always_comb begin
    do_push     = push_req && (!full || pop);
    overrun_set = push_req && full && !pop && !flush;
    if (flush) begin
      rd_ptr_d  = '0;
      wr_ptr_d  = push_req ? PtrW'(1) : '0;
      count_d   = push_req ? CntW'(1) : '0;
      mem_we    = push_req;
      mem_waddr = '0;
    end else begin
      rd_ptr_d  = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
      wr_ptr_d  = do_push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
      count_d   = count_q + (do_push ? CntW'(1) : '0) - (pop ? CntW'(1) : '0);
      mem_we    = do_push;
      mem_waddr = wr_ptr_q;
    end
    overrun_d   = (overrun_q & ~(status_wr & req_wdata[2])) | overrun_set;
    frame_err_d = (frame_err_q & ~(status_wr & req_wdata[3])) | frame_set;
`ifdef UART_RX_PARITY_EN
    parity_err_d = (parity_err_q & ~(status_wr & req_wdata[5])) | parity_set;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= StIdle;
      sc_q        <= 4'd0;
      bit_q       <= 3'd0;
      shift_q     <= 8'd0;
      div_cnt_q   <= 16'd0;
      baud_div_q  <= DIV_RST;
      rx_en_q     <= 1'b0;
      irq_en_q    <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= 8'd0;
`ifdef UART_RX_PARITY_EN
      par_en_q     <= 1'b0;
      par_odd_q    <= 1'b0;
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      sync1_q     <= uart_rx;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      sc_q        <= sc_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      div_cnt_q   <= div_cnt_d;
      baud_div_q  <= baud_div_d;
      rx_en_q     <= rx_en_d;
      irq_en_q    <= irq_en_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      if (mem_we) mem_q[mem_waddr] <= shift_q;
`ifdef UART_RX_PARITY_EN
      par_en_q     <= par_en_d;
      par_odd_q    <= par_odd_d;
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  always_comb begin
    rdata = 32'd0;
    if (rd_en) begin
      unique case (offset)
        OffRxData: rdata[7:0] = empty ? 8'd0 : mem_q[rd_ptr_q];
        OffStatus: begin
          rdata[0]    = ~empty;
          rdata[1]    = full;
          rdata[2]    = overrun_q;
          rdata[3]    = frame_err_q;
          rdata[4]    = busy;
          rdata[5]    = parity_err;
          rdata[12:8] = 5'(count_q);
        end
        OffCtrl: begin
          rdata[0] = rx_en_q;
          rdata[1] = irq_en_q;
`ifdef UART_RX_PARITY_EN
          rdata[3] = par_en_q;
          rdata[4] = par_odd_q;
`endif
        end
        OffBaud: rdata[15:0] = baud_div_q;
        default: rdata = 32'd0;
      endcase
    end
  end

  assign irq_rx = irq_en_q & (~empty | overrun_q | frame_err_q | parity_err);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed register/frame scenarios, then randomized frames whose
// expected bytes are queued by the serial driver and checked by an independent bus monitor.
module tb_uart_rx_ctrl;

  localparam logic [31:0] ARxData = 32'h4000_0204;
  localparam logic [31:0] AStatus = 32'h4000_0208;
  localparam logic [31:0] ACtrl   = 32'h4000_020C;
  localparam logic [31:0] ABaud   = 32'h4000_0210;
  localparam int          NRand   = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_write;
  logic [31:0] req_addr, req_wdata, rdata;
  logic [3:0]  req_wstrb;
  logic        uart_rx, irq_rx;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] rd;
  logic [31:0] last_s;
  logic        saw_busy;
  int          rand_div;
  int          got_n;
  int          cyc;

  uart_rx_ctrl #(.FIFO_DEPTH(4), .DIV_RST(16'd27)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .rdata     (rdata),
    .uart_rx   (uart_rx),
    .irq_rx    (irq_rx)
  );

  always #5 clk = ~clk;

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, got, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = addr; req_wdata = data;
    @(posedge clk);
    #1 req_valid = 1'b0; req_write = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = addr;
    #1 data = rdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic check_reg(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(addr, d);
    check(name, d, exp);
  endtask

  // One 8N1 frame at 16*div clocks per bit; stop_bit=0 forces a framing error
  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int div);
    @(negedge clk);
    uart_rx = 1'b0;
    repeat (16 * div) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = data[i];
      repeat (16 * div) @(negedge clk);
    end
    uart_rx = stop_bit;
    repeat (16 * div) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; req_wstrb = 4'hF; uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    check_reg("reset_status", AStatus, 32'h0);
    check_reg("reset_ctrl", ACtrl, 32'h0);
    check_reg("reset_bauddiv", ABaud, 32'd27);
    check_reg("reset_rxdata", ARxData, 32'h0);
    check("reset_irq", {31'd0, irq_rx}, 32'd0);

    bus_write(ABaud, 32'd1);
    bus_write(ACtrl, 32'h3);

    // Good frame
    send_frame(8'hA5, 1'b1, 1);
    check_reg("a5_status", AStatus, 32'h0000_0101);
    check("a5_irq", {31'd0, irq_rx}, 32'd1);
    check_reg("a5_rxdata", ARxData, 32'hA5);
    check_reg("a5_status_after", AStatus, 32'h0);
    check("a5_irq_after", {31'd0, irq_rx}, 32'd0);

    // Bad stop bit
    send_frame(8'h3C, 1'b0, 1);
    repeat (40) @(negedge clk);
    check_reg("ferr_status", AStatus, 32'h0000_0008);
    check("ferr_irq", {31'd0, irq_rx}, 32'd1);
    bus_write(AStatus, 32'h8);
    check_reg("ferr_cleared", AStatus, 32'h0);
    check("ferr_irq_cleared", {31'd0, irq_rx}, 32'd0);

    // Short low pulse: start rejected at mid-bit
    saw_busy = 1'b0;
    fork
      begin
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
      end
      begin
        for (int i = 0; i < 30; i++) begin
          bus_read(AStatus, last_s);
          if (last_s[4]) saw_busy = 1'b1;
        end
      end
    join
    check("glitch_busy_seen", {31'd0, saw_busy}, 32'd1);
    check("glitch_status", last_s, 32'h0);

    // Overrun on 5th frame
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1);
    check_reg("ovr_status", AStatus, 32'h0000_0407);
    for (int i = 1; i <= 4; i++) check_reg("ovr_rxdata", ARxData, 32'(i));
    check_reg("ovr_rxdata_empty", ARxData, 32'h0);
    check_reg("ovr_status_drained", AStatus, 32'h0000_0004);
    bus_write(AStatus, 32'h4);
    check_reg("ovr_cleared", AStatus, 32'h0);

    // Pop in the mid-stop cycle of a frame arriving on a full FIFO
    for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 1'b1, 1);
    check_reg("full_status", AStatus, 32'h0000_0403);
    fork
      send_frame(8'h15, 1'b1, 1);
      begin
        @(negedge clk);
        repeat (153) @(negedge clk);
        bus_read(ARxData, rd);
      end
    join
    check("midstop_pop_data", rd, 32'h11);
    check_reg("midstop_status", AStatus, 32'h0000_0403);
    check_reg("midstop_next", ARxData, 32'h12);

    // Asynchronous reset in DATA bit 3
    fork
      send_frame(8'h33, 1'b1, 1);
      begin
        @(negedge clk);
        repeat (70) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_irq", {31'd0, irq_rx}, 32'd0);
        check("rst_rdata_idle", rdata, 32'h0);
        bus_read(AStatus, rd);
        check("rst_status", rd, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    check_reg("post_rst_status", AStatus, 32'h0);
    check_reg("post_rst_ctrl", ACtrl, 32'h0);
    bus_write(ABaud, 32'd1);
    bus_write(ACtrl, 32'h3);
    send_frame(8'h5A, 1'b1, 1);
    check_reg("5a_status", AStatus, 32'h0000_0101);
    check_reg("5a_rxdata", ARxData, 32'h5A);
    check_reg("5a_status_after", AStatus, 32'h0);

    // Flush
    send_frame(8'h66, 1'b1, 1);
    send_frame(8'h77, 1'b1, 1);
    check_reg("flush_pre", AStatus, 32'h0000_0201);
    bus_write(ACtrl, 32'h7);
    check_reg("flush_status", AStatus, 32'h0);
    check_reg("flush_ctrl", ACtrl, 32'h3);

    // Register corner cases
    bus_write(ABaud, 32'h0);
    check_reg("baud_zero", ABaud, 32'd1);
    bus_write(ACtrl, 32'hFF);
`ifdef UART_RX_PARITY_EN
    check_reg("ctrl_mask", ACtrl, 32'h1B);
`else
    check_reg("ctrl_mask", ACtrl, 32'h03);
`endif
    bus_write(ACtrl, 32'h3);
    bus_write(32'h4000_0214, 32'hFFFF_FFFF);
    check_reg("unmapped_read", 32'h4000_0214, 32'h0);

    // Randomized frames: driver queues expected bytes, monitor pops and compares
    rand_div = int'($urandom_range(1, 3));
    bus_write(ABaud, 32'(rand_div));
    got_n = 0;
    cyc   = 0;
    fork
      begin
        for (int k = 0; k < NRand; k++) begin
          logic [7:0] b;
          b = 8'($urandom);
          exp_q.push_back(b);
          send_frame(b, 1'b1, rand_div);
          repeat ($urandom_range(0, 30)) @(negedge clk);
        end
      end
      begin
        logic [31:0] s, d;
        while (got_n < NRand && cyc < 40000) begin
          bus_read(AStatus, s);
          cyc++;
          if (s[0]) begin
            bus_read(ARxData, d);
            cyc++;
            if (exp_q.size() == 0) begin
              check("rand_unexpected_byte", d, 32'hFFFF_FFFF);
            end else begin
              check("rand_byte", d, {24'd0, exp_q.pop_front()});
            end
            got_n++;
          end
        end
      end
    join
    check("rand_count", 32'(got_n), 32'(NRand));
    check_reg("rand_final_status", AStatus, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
